pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, sole clock, all state changes on posedge; reset in 1, synchronous active-high.
REQ-002 SHALL have inputs d_rs, d_rt (5 each): D-stage source register numbers; d_tuse_rs, d_tuse_rt (2 each): cycles until use, 3 = not used.
REQ-003 SHALL have inputs e_wa, m_wa (5 each): destination register of E/M instruction; e_tnew, m_tnew (2 each): cycles until result ready, stage-relative.
REQ-004 SHALL have inputs d_md (1): D instruction uses HI/LO or the MDU; e_md_start (1): E instruction starts the MDU; e_md_div (1): 1 = div/divu, 0 = mult/multu.
REQ-005 SHALL have inputs d_eret (1): D holds eret; e_mtc0_epc, m_mtc0_epc (1 each): E/M holds mtc0 to EPC; req (1): CP0 exception/interrupt request, M stage.
REQ-006 SHALL have outputs pc_en, fd_en, de_clr, em_clr (1 each), md_busy (1), md_done (1), stall (1), stall_cycles (16).

Function
REQ-007 SHALL assert data stall when d_rs!=0, d_rs==e_wa, d_tuse_rs<e_tnew; same test for d_rt, and for m_wa/m_tnew.
REQ-008 SHALL assert eret stall when d_eret and (e_mtc0_epc or m_mtc0_epc).
REQ-009 SHALL assert MDU stall when d_md and (md_busy or e_md_start).
REQ-010 SHALL drive stall = data|eret|MDU stall, combinational, forced 0 when req=1.
REQ-011 With stall=1 and req=0: pc_en=0, fd_en=0, de_clr=1, em_clr=0.
REQ-012 With req=1: pc_en=1, fd_en=1, de_clr=1, em_clr=1, regardless of other inputs.
REQ-013 Otherwise: pc_en=1, fd_en=1, de_clr=0, em_clr=0.
REQ-014 SHALL hold 4-bit md_cnt; on posedge with e_md_start=1, md_busy=0, req=0, load 5 (mult) or 10 (div).
REQ-015 SHALL ignore e_md_start while md_busy=1 (cannot occur legally; no reload).
REQ-016 SHALL ignore e_md_start when req=1 in the same cycle (E instruction flushed).
REQ-017 SHALL decrement md_cnt by 1 each cycle while nonzero; md_busy = (md_cnt!=0), registered-derived.
REQ-018 SHALL pulse md_done for exactly one cycle, the cycle after md_cnt transitions 1->0.
REQ-019 req during md_busy SHALL NOT abort the count; operation completes.
REQ-020 Mult: md_busy high 5 cycles after start edge; div: 10 cycles.
REQ-021 stall_cycles SHALL increment by 1 each posedge where stall=1, saturating at 16'hFFFF, never wrapping.

Reset
REQ-022 reset=1 at posedge SHALL clear md_cnt, md_done, stall_cycles to 0, overriding all other inputs including e_md_start.
REQ-023 During and after reset, combinational outputs follow REQ-010..013 with md_busy=0.
REQ-024 Reset mid-operation SHALL drop md_busy on the next cycle with no md_done pulse.

Configuration
REQ-025 Macro PIPE_CTRL_MDU_EN SHALL, when defined, include md_cnt, MDU stall, md_busy, md_done.
REQ-026 Without PIPE_CTRL_MDU_EN: no counter logic, md_busy=0, md_done=0, d_md/e_md_start/e_md_div ignored; all other behaviour identical.

Structure
REQ-027 Shared package SHALL hold MDU latency constants (MULT_CYCLES=5, DIV_CYCLES=10) and TUSE_NONE=2'd3.
REQ-028 Sub-module mdu_timer SHALL contain md_cnt, md_busy, md_done; hazard compare stays in pipe_ctrl.

Verification
REQ-029 d_rs=5, d_tuse_rs=0, e_wa=5, e_tnew=1 -> stall=1, pc_en=0, de_clr=1, stall_cycles +1.
REQ-030 d_rs=0, e_wa=0, e_tnew=2, d_tuse_rs=0 -> stall=0 ($0 never stalls).
REQ-031 e_md_div=1, e_md_start=1 one cycle -> md_busy high 10 cycles, md_done pulse cycle 11; d_md=1 stalls through busy.
REQ-032 req=1 with data stall active -> stall=0, pc_en=1, fd_en=1, de_clr=1, em_clr=1.
REQ-033 Start mult, assert reset at cycle 2 -> md_busy=0 next cycle, no md_done, stall_cycles=0.
REQ-034 Hold stall 70000 cycles -> stall_cycles=16'hFFFF, unchanged thereafter.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared MDU latencies, Tuse encoding and hazard compare helper
package pipe_ctrl_pkg;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;
  localparam logic [1:0] TUSE_NONE   = 2'd3;

  typedef logic [4:0] reg_idx_t;

  // $0 is hardwired, so it never creates a dependency
  function automatic logic raw_hazard(reg_idx_t src, logic [1:0] tuse,
                                      reg_idx_t wa, logic [1:0] tnew);
    return (src != 5'd0) && (src == wa) && (tuse != TUSE_NONE) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/pipe_ctrl_mdu_timer.sv
// rtl/pipe_ctrl_mdu_timer.sv - multiply/divide latency counter producing md_busy and md_done
module mdu_timer
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_div,
  input  logic i_req,
  output logic o_md_busy,
  output logic o_md_done
);

  logic [3:0] r_cnt;
  logic       r_done;

  // A start while busy is ignored; a flushing req blocks only the load, never a running count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 4'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_cnt == 4'd1);
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else if (i_start && !i_req) begin
        r_cnt <= i_div ? DIV_CYCLES : MULT_CYCLES;
      end
    end
  end

  assign o_md_busy = (r_cnt != 4'd0);
  assign o_md_done = r_done;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/stall/flush controller; MDU timing enabled by PIPE_CTRL_MDU_EN
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  e_wa,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        d_md,
  input  logic        e_md_start,
  input  logic        e_md_div,
  input  logic        d_eret,
  input  logic        e_mtc0_epc,
  input  logic        m_mtc0_epc,
  input  logic        req,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_clr,
  output logic        em_clr,
  output logic        md_busy,
  output logic        md_done,
  output logic        stall,
  output logic [15:0] stall_cycles
);

  logic        w_data_stall;
  logic        w_eret_stall;
  logic        w_md_stall;
  logic [15:0] r_stall_cycles;

  assign w_data_stall = raw_hazard(d_rs, d_tuse_rs, e_wa, e_tnew)
                      | raw_hazard(d_rt, d_tuse_rt, e_wa, e_tnew)
                      | raw_hazard(d_rs, d_tuse_rs, m_wa, m_tnew)
                      | raw_hazard(d_rt, d_tuse_rt, m_wa, m_tnew);

  assign w_eret_stall = d_eret & (e_mtc0_epc | m_mtc0_epc);

`ifdef PIPE_CTRL_MDU_EN
  mdu_timer u_mdu_timer (
    .clk       (clk),
    .reset     (reset),
    .i_start   (e_md_start),
    .i_div     (e_md_div),
    .i_req     (req),
    .o_md_busy (md_busy),
    .o_md_done (md_done)
  );

  assign w_md_stall = d_md & (md_busy | e_md_start);
`else
  logic w_unused_md;

  assign w_unused_md = d_md ^ e_md_start ^ e_md_div;
  assign md_busy     = 1'b0;
  assign md_done     = 1'b0;
  assign w_md_stall  = 1'b0;
`endif

  // An exception flushes everything younger than M, so stalling would be pointless
  assign stall  = (w_data_stall | w_eret_stall | w_md_stall) & ~req;
  assign pc_en  = ~stall;
  assign fd_en  = ~stall;
  assign de_clr = stall | req;
  assign em_clr = req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
    end else if (stall && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl (vector table plus MDU/reset/saturation sequences)
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, e_wa, m_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_md, e_md_start, e_md_div, d_eret, e_mtc0_epc, m_mtc0_epc, req;
  logic        pc_en, fd_en, de_clr, em_clr, md_busy, md_done, stall;
  logic [15:0] stall_cycles;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .e_wa(e_wa), .m_wa(m_wa), .e_tnew(e_tnew), .m_tnew(m_tnew),
    .d_md(d_md), .e_md_start(e_md_start), .e_md_div(e_md_div),
    .d_eret(d_eret), .e_mtc0_epc(e_mtc0_epc), .m_mtc0_epc(m_mtc0_epc), .req(req),
    .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr), .em_clr(em_clr),
    .md_busy(md_busy), .md_done(md_done), .stall(stall), .stall_cycles(stall_cycles)
  );

`ifdef PIPE_CTRL_MDU_EN
  localparam logic MDU = 1'b1;
`else
  localparam logic MDU = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] rs, rt;
    logic [1:0] tu_rs, tu_rt;
    logic [4:0] ewa, mwa;
    logic [1:0] etn, mtn;
    logic       md, st, eret, eepc, mepc, rq;
    logic       x_stall, x_pc, x_fd, x_de, x_em;
  } vec_t;

  typedef struct packed {
    logic        stall, pc, fd, de, em, busy, done;
    logic [15:0] sc;
  } exp_t;

  exp_t        q[$];
  vec_t        vecs[13];
  logic [15:0] m_sc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    e_wa = 5'd0; m_wa = 5'd0; e_tnew = 2'd0; m_tnew = 2'd0;
    d_md = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
    d_eret = 1'b0; e_mtc0_epc = 1'b0; m_mtc0_epc = 1'b0; req = 1'b0;
  endtask

  task automatic step(input string tag, input logic xs, input logic xp, input logic xf,
                      input logic xd, input logic xe, input logic xb, input logic xdn);
    exp_t e, g;
    e.stall = xs; e.pc = xp; e.fd = xf; e.de = xd; e.em = xe;
    e.busy = xb; e.done = xdn; e.sc = m_sc;
    q.push_back(e);
    @(negedge clk);
    g = q.pop_front();
    chk({tag, ".stall"},  32'(stall),        32'(g.stall));
    chk({tag, ".pc_en"},  32'(pc_en),        32'(g.pc));
    chk({tag, ".fd_en"},  32'(fd_en),        32'(g.fd));
    chk({tag, ".de_clr"}, 32'(de_clr),       32'(g.de));
    chk({tag, ".em_clr"}, 32'(em_clr),       32'(g.em));
    chk({tag, ".busy"},   32'(md_busy),      32'(g.busy));
    chk({tag, ".done"},   32'(md_done),      32'(g.done));
    chk({tag, ".sc"},     32'(stall_cycles), 32'(g.sc));
    @(posedge clk);
    if (reset) m_sc = 16'd0;
    else if (xs && m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    #1;
  endtask

  // Pipeline control outputs follow directly from the expected stall and req
  task automatic stepd(input string tag, input logic xs, input logic xb, input logic xdn);
    if (req) step(tag, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, xb, xdn);
    else if (xs) step(tag, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, xb, xdn);
    else step(tag, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, xb, xdn);
  endtask

  initial begin
    //          rs     rt     tus   tut   ewa    mwa    etn   mtn   md st er ee me rq   st pc fd de em
    vecs[0]  = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 5'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0};
    vecs[1]  = '{5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 5'd0, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0};
    vecs[2]  = '{5'd0, 5'd7, 2'd3, 2'd1, 5'd0, 5'd7, 2'd0, 2'd2, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0};
    vecs[3]  = '{5'd0, 5'd7, 2'd3, 2'd2, 5'd0, 5'd7, 2'd0, 2'd2, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0};
    vecs[4]  = '{5'd3, 5'd0, 2'd3, 2'd3, 5'd3, 5'd0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0};
    vecs[5]  = '{5'd4, 5'd0, 2'd0, 2'd3, 5'd5, 5'd0, 2'd3, 2'd0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0};
    vecs[6]  = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 1, 0};
    vecs[7]  = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0, 0, 0, 1, 0, 1, 0,   1, 0, 0, 1, 0};
    vecs[8]  = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 1, 1, 0,   0, 1, 1, 0, 0};
    vecs[9]  = '{5'd5, 5'd0, 2'd0, 2'd3, 5'd5, 5'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1, 1};
    vecs[10] = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1, 1};
    vecs[11] = '{5'd0, 5'd9, 2'd3, 2'd0, 5'd9, 5'd0, 2'd1, 2'd0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0};
    vecs[12] = '{5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 5'd0, 2'd0, 2'd0, 1, 1, 0, 0, 0, 0, MDU, !MDU, !MDU, MDU, 0};

    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_sc = 16'd0;
    stepd("rst_idle", 1'b0, 1'b0, 1'b0);
    d_rs = 5'd5; d_tuse_rs = 2'd0; e_wa = 5'd5; e_tnew = 2'd1;
    stepd("rst_hazard", 1'b1, 1'b0, 1'b0);
    set_idle();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      d_rs = vecs[i].rs; d_rt = vecs[i].rt; d_tuse_rs = vecs[i].tu_rs; d_tuse_rt = vecs[i].tu_rt;
      e_wa = vecs[i].ewa; m_wa = vecs[i].mwa; e_tnew = vecs[i].etn; m_tnew = vecs[i].mtn;
      d_md = vecs[i].md; e_md_start = vecs[i].st; e_md_div = 1'b0;
      d_eret = vecs[i].eret; e_mtc0_epc = vecs[i].eepc; m_mtc0_epc = vecs[i].mepc; req = vecs[i].rq;
      step($sformatf("vec%0d", i), vecs[i].x_stall, vecs[i].x_pc, vecs[i].x_fd,
           vecs[i].x_de, vecs[i].x_em, 1'b0, 1'b0);
    end

    set_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_sc = 16'd0;
    reset = 1'b0;

    // Divide with d_md waiting; a req mid-count and a stray start must not disturb it
    e_md_start = 1'b1; e_md_div = 1'b1;
    stepd("div_start", 1'b0, 1'b0, 1'b0);
    e_md_start = 1'b0; e_md_div = 1'b0; d_md = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      req = (k == 3);
      e_md_start = (k == 5);
      stepd($sformatf("div_k%0d", k), MDU && (k <= 10) && !req, MDU && (k <= 10), MDU && (k == 11));
    end
    set_idle();

    e_md_start = 1'b1; req = 1'b1;
    stepd("start_req", 1'b0, 1'b0, 1'b0);
    set_idle();
    stepd("start_req_after", 1'b0, 1'b0, 1'b0);

    // Multiply interrupted by reset: busy drops, no done, counter cleared
    e_md_start = 1'b1;
    stepd("mul_start", 1'b0, 1'b0, 1'b0);
    e_md_start = 1'b0; d_md = 1'b1;
    stepd("mul_k1", MDU, MDU, 1'b0);
    reset = 1'b1;
    stepd("mul_k2_rst", MDU, MDU, 1'b0);
    reset = 1'b0;
    for (int k = 3; k <= 8; k++) stepd($sformatf("mul_k%0d", k), 1'b0, 1'b0, 1'b0);
    set_idle();

    d_rs = 5'd5; d_tuse_rs = 2'd0; e_wa = 5'd5; e_tnew = 2'd1;
    stepd("sat_begin", 1'b1, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    m_sc = 16'hFFFF;
    for (int k = 0; k < 3; k++) stepd($sformatf("sat%0d", k), 1'b1, 1'b0, 1'b0);
    set_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
